// File: rtl/ladybird_program_loader_if.sv
// ladybird_bus: single-beat write bus between a primary (loader) and the
// instruction-bus arbitrator. The primary holds req/addr/data/wstrb until gnt.
interface ladybird_bus #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int WB = XLEN / 8;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   data;
  logic [WB-1:0]     wstrb;
  logic              gnt;

  modport primary   (output req, addr, data, wstrb, input  gnt);
  modport secondary (input  req, addr, data, wstrb, output gnt);
endinterface

// File: rtl/ladybird_program_loader.sv
// ladybird_program_loader: receives a framed program image byte by byte,
// writes it word by word into instruction RAM, verifies an XOR checksum,
// returns a 'K'/'E' acknowledgement and releases the core on success.
module ladybird_program_loader #(
  parameter int                XLEN        = 32,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                MAX_WORDS   = 1024,
  parameter int                COUNT_BYTES = 2
) (
  input  logic         clk,
  input  logic         anrst,
  input  logic [7:0]   i_data,
  input  logic         i_valid,
  output logic         i_ready,
  output logic [7:0]   o_data,
  output logic         o_valid,
  input  logic         o_ready,
  input  logic         reload,
  ladybird_bus.primary bus,
  output logic         core_nrst,
  output logic         done,
  output logic         error
);

  localparam int WB    = XLEN / 8;
  localparam int CNT_W = 8 * COUNT_BYTES;
  localparam int K_W   = $clog2(MAX_WORDS + 1);
  localparam int HI_W  = (COUNT_BYTES > 1) ? $clog2(COUNT_BYTES) : 1;
  localparam int BI_W  = (WB > 1) ? $clog2(WB) : 1;
  localparam int CMP_W = CNT_W + 33;

  typedef enum logic [2:0] {
    S_HEADER, S_PAYLOAD, S_WRITE, S_CHECK, S_OK_ACK, S_ERR_ACK, S_RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HI_W-1:0]   hdr_idx_q, hdr_idx_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        xor_q, xor_d;
  logic              reload_pend_q, reload_pend_d;
  logic              error_q, error_d;

  logic             accept;
  logic             hdr_last;
  logic             byte_last;
  logic             k_last;
  logic [CNT_W-1:0] count_shift;
  logic             rearm;
  logic             restart;

  assign accept      = i_valid && i_ready;
  assign hdr_last    = (hdr_idx_q == HI_W'(COUNT_BYTES - 1));
  assign byte_last   = (byte_idx_q == BI_W'(WB - 1));
  assign k_last      = ((CMP_W'(k_q) + CMP_W'(1)) == CMP_W'(count_q));
  assign count_shift = (count_q >> 8) | (CNT_W'(i_data) << (CNT_W - 8));
  // A reload outside WRITE acts at once; inside WRITE it waits for the grant
  // so the in-flight word is never abandoned mid-handshake.
  assign rearm   = (reload && (state_q != S_WRITE)) ||
                   ((state_q == S_WRITE) && bus.gnt && (reload_pend_q || reload));
  assign restart = rearm || ((state_q == S_ERR_ACK) && o_ready);

  // State register.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) state_q <= S_HEADER;
    else        state_q <= state_d;
  end

  // Datapath registers: header count, word assembly, word index, address, checksum.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      count_q       <= '0;
      hdr_idx_q     <= '0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      k_q           <= '0;
      addr_q        <= BASE_ADDR;
      xor_q         <= '0;
      reload_pend_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      count_q       <= count_d;
      hdr_idx_q     <= hdr_idx_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      k_q           <= k_d;
      addr_q        <= addr_d;
      xor_q         <= xor_d;
      reload_pend_q <= reload_pend_d;
      error_q       <= error_d;
    end
  end

  // Next-state decode; reload overrides everything except an open write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HEADER: begin
        if (accept && hdr_last) begin
          if (CMP_W'(count_shift) > CMP_W'(MAX_WORDS)) state_d = S_ERR_ACK;
          else if (count_shift == '0)                  state_d = S_CHECK;
          else                                         state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (accept && byte_last) state_d = S_WRITE;
      S_WRITE: begin
        if (bus.gnt) begin
          if (reload_pend_q || reload) state_d = S_HEADER;
          else if (k_last)             state_d = S_CHECK;
          else                         state_d = S_PAYLOAD;
        end
      end
      S_CHECK:   if (accept) state_d = ((xor_q ^ i_data) == 8'h00) ? S_OK_ACK : S_ERR_ACK;
      S_OK_ACK:  if (o_ready) state_d = S_RUN;
      S_ERR_ACK: if (o_ready) state_d = S_HEADER;
      S_RUN:     state_d = S_RUN;
      default:   state_d = S_HEADER;
    endcase
    if (reload && (state_q != S_WRITE)) state_d = S_HEADER;
  end

  // Datapath next values.
  always_comb begin
    count_d       = count_q;
    hdr_idx_d     = hdr_idx_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    k_d           = k_q;
    addr_d        = addr_q;
    xor_d         = xor_q;
    reload_pend_d = reload_pend_q;
    error_d       = error_q;
    if (accept) xor_d = xor_q ^ i_data;
    case (state_q)
      S_HEADER: begin
        if (accept) begin
          count_d   = count_shift;
          hdr_idx_d = hdr_last ? '0 : hdr_idx_q + HI_W'(1);
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          word_d[8*byte_idx_q +: 8] = i_data;
          byte_idx_d                = byte_last ? '0 : byte_idx_q + BI_W'(1);
        end
      end
      S_WRITE: begin
        if (reload) reload_pend_d = 1'b1;
        if (bus.gnt) begin
          k_d    = k_q + K_W'(1);
          addr_d = addr_q + ADDR_W'(WB);
        end
      end
      default: ;
    endcase
    if ((state_d == S_ERR_ACK) && (state_q != S_ERR_ACK)) error_d = 1'b1;
    if (state_d == S_OK_ACK) error_d = 1'b0;
    if (restart) begin
      count_d    = '0;
      hdr_idx_d  = '0;
      byte_idx_d = '0;
      k_d        = '0;
      addr_d     = BASE_ADDR;
      xor_d      = '0;
    end
    if (rearm) begin
      reload_pend_d = 1'b0;
      error_d       = 1'b0;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    i_ready   = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    o_valid   = (state_q == S_OK_ACK) || (state_q == S_ERR_ACK);
    o_data    = (state_q == S_OK_ACK)  ? 8'h4B :
                (state_q == S_ERR_ACK) ? 8'h45 : 8'h00;
    core_nrst = (state_q == S_RUN);
    done      = (state_q == S_RUN);
    error     = error_q;
    bus.req   = (state_q == S_WRITE);
    bus.addr  = addr_q;
    bus.data  = word_q;
    bus.wstrb = (state_q == S_WRITE) ? '1 : '0;
  end

endmodule

// File: tb/tb_ladybird_program_loader.sv
// Directed bench for ladybird_program_loader: two instances (default sizing,
// and a 4-word RAM at the top of the address space), shared stimulus with a
// select line, and a write scoreboard fed when frames are driven.
module tb_ladybird_program_loader;

  logic       clk = 1'b0;
  logic       anrst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       reload;
  logic       sel;
  logic       gnt = 1'b1;

  logic       a_i_ready, a_o_valid, a_core_nrst, a_done, a_error;
  logic       b_i_ready, b_o_valid, b_core_nrst, b_done, b_error;
  logic [7:0] a_o_data, b_o_data;

  ladybird_bus #(.XLEN(32), .ADDR_W(32)) bus_a ();
  ladybird_bus #(.XLEN(32), .ADDR_W(32)) bus_b ();
  assign bus_a.gnt = gnt;
  assign bus_b.gnt = gnt;

  ladybird_program_loader #(.XLEN(32), .ADDR_W(32), .BASE_ADDR(32'h0),
                            .MAX_WORDS(1024), .COUNT_BYTES(2)) dut_a (
    .clk(clk), .anrst(anrst), .i_data(i_data), .i_valid(i_valid & ~sel),
    .i_ready(a_i_ready), .o_data(a_o_data), .o_valid(a_o_valid),
    .o_ready(o_ready & ~sel), .reload(reload & ~sel), .bus(bus_a),
    .core_nrst(a_core_nrst), .done(a_done), .error(a_error));

  ladybird_program_loader #(.XLEN(32), .ADDR_W(32), .BASE_ADDR(32'hFFFF_FFFC),
                            .MAX_WORDS(4), .COUNT_BYTES(2)) dut_b (
    .clk(clk), .anrst(anrst), .i_data(i_data), .i_valid(i_valid & sel),
    .i_ready(b_i_ready), .o_data(b_o_data), .o_valid(b_o_valid),
    .o_ready(o_ready & sel), .reload(reload & sel), .bus(bus_b),
    .core_nrst(b_core_nrst), .done(b_done), .error(b_error));

  always #5 clk = ~clk;

  logic        cur_i_ready, cur_o_valid, cur_core_nrst, cur_done, cur_error, cur_req;
  logic [7:0]  cur_o_data;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_wstrb;
  always_comb begin
    cur_i_ready   = sel ? b_i_ready   : a_i_ready;
    cur_o_valid   = sel ? b_o_valid   : a_o_valid;
    cur_o_data    = sel ? b_o_data    : a_o_data;
    cur_core_nrst = sel ? b_core_nrst : a_core_nrst;
    cur_done      = sel ? b_done      : a_done;
    cur_error     = sel ? b_error     : a_error;
    cur_req       = sel ? bus_b.req   : bus_a.req;
    cur_addr      = sel ? bus_b.addr  : bus_a.addr;
    cur_data      = sel ? bus_b.data  : bus_a.data;
    cur_wstrb     = sel ? bus_b.wstrb : bus_a.wstrb;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] stall_addr = 32'h0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          hs_count   = 0;

  // Bus responder and write scoreboard: every requesting cycle must match the
  // oldest expected write, which also proves the request is held while stalled.
  always @(negedge clk) begin
    if (cur_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_req", cur_req, 1'b0);
        gnt = 1'b1;
      end else begin
        chk("wr_addr",  cur_addr,  exp_q[0].addr);
        chk("wr_data",  cur_data,  exp_q[0].data);
        chk("wr_wstrb", cur_wstrb, 4'hF);
        if (stall_left > 0 && cur_addr == stall_addr) begin
          gnt = 1'b0;
          stall_left--;
          stall_seen++;
        end else begin
          gnt = 1'b1;
          void'(exp_q.pop_front());
          hs_count++;
        end
      end
    end else begin
      gnt = 1'b1;
    end
  end

  logic [31:0] img [0:7];

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (cur_i_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("i_ready_wait", cur_i_ready, 1'b1);
    i_data  = b;
    i_valid = 1'b1;
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [31:0] base, input logic [7:0] flip);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < 2; i++) begin
      b = 8'(n >> (8 * i));
      x ^= b;
      send_byte(b);
    end
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{addr: base + 32'(4 * k), data: img[k]});
      for (int j = 0; j < 4; j++) begin
        b = img[k][8*j +: 8];
        x ^= b;
        send_byte(b);
      end
    end
    send_byte(x ^ flip);
  endtask

  // Expects the acknowledgement on the cycle right after the last accepted byte.
  task automatic check_ack(input logic [7:0] exp, input int delay, input logic ok);
    @(negedge clk);
    chk("ack_valid", cur_o_valid, 1'b1);
    chk("ack_data",  cur_o_data,  exp);
    chk("ack_error", cur_error,   !ok);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("ack_hold_valid", cur_o_valid, 1'b1);
      chk("ack_hold_data",  cur_o_data,  exp);
    end
    o_ready = 1'b1;
    @(posedge clk);
    #1 o_ready = 1'b0;
    @(negedge clk);
    chk("core_nrst",   cur_core_nrst, ok);
    chk("done",        cur_done,      ok);
    chk("o_valid_clr", cur_o_valid,   1'b0);
    chk("i_ready_ack", cur_i_ready,   !ok);
    chk("error_after", cur_error,     !ok);
    chk("wq_empty",    exp_q.size(),  0);
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int hs0, st0, n;
    anrst = 1'b0; i_data = 8'h00; i_valid = 1'b0; o_ready = 1'b0;
    reload = 1'b0; sel = 1'b0;
    #12;
    chk("rst_i_ready",   a_i_ready,   1'b1);
    chk("rst_req",       bus_a.req,   1'b0);
    chk("rst_addr",      bus_a.addr,  32'h0);
    chk("rst_data",      bus_a.data,  32'h0);
    chk("rst_wstrb",     bus_a.wstrb, 4'h0);
    chk("rst_o_valid",   a_o_valid,   1'b0);
    chk("rst_o_data",    a_o_data,    8'h00);
    chk("rst_core_nrst", a_core_nrst, 1'b0);
    chk("rst_done",      a_done,      1'b0);
    chk("rst_error",     a_error,     1'b0);
    chk("rst_b_addr",    bus_b.addr,  32'hFFFF_FFFC);
    @(negedge clk);
    anrst = 1'b1;

    // Two-word image, grant always high.
    img[0] = 32'h0FF0_0093; img[1] = 32'h0000_82A3;
    hs0 = hs_count;
    send_frame(2, 32'h0, 8'h00);
    check_ack(8'h4B, 0, 1'b1);
    chk("t1_handshakes", hs_count - hs0, 2);

    // Reload in RUN drops the core reset on the next cycle.
    pulse_reload();
    @(negedge clk);
    chk("run_reload_nrst", cur_core_nrst, 1'b0);
    chk("run_reload_done", cur_done,      1'b0);
    chk("run_reload_rdy",  cur_i_ready,   1'b1);

    // Same image, word 1 stalled five cycles; ack accepted late.
    hs0 = hs_count; st0 = stall_seen;
    stall_addr = 32'h4; stall_left = 5;
    send_frame(2, 32'h0, 8'h00);
    check_ack(8'h4B, 2, 1'b1);
    chk("t2_handshakes", hs_count - hs0, 2);
    chk("t2_stalls",     stall_seen - st0, 5);
    pulse_reload();

    // Corrupted checksum, then a good frame straight after the error.
    send_frame(2, 32'h0, 8'h01);
    check_ack(8'h45, 0, 1'b0);
    send_frame(2, 32'h0, 8'h00);
    check_ack(8'h4B, 0, 1'b1);
    pulse_reload();

    // Empty image.
    send_frame(0, 32'h0, 8'h00);
    check_ack(8'h4B, 0, 1'b1);
    pulse_reload();

    // Reload mid-word, coincident with an offered byte which must be dropped.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    reload = 1'b1; i_valid = 1'b1; i_data = 8'hAA;
    @(posedge clk);
    #1 reload = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("pl_reload_rdy",   cur_i_ready, 1'b1);
    chk("pl_reload_ovld",  cur_o_valid, 1'b0);
    chk("pl_reload_req",   cur_req,     1'b0);
    img[0] = 32'hDEAD_BEEF;
    send_frame(1, 32'h0, 8'h00);
    check_ack(8'h4B, 0, 1'b1);
    pulse_reload();

    // Reload while a write is stalled: the write finishes, then HEADER.
    img[0] = 32'h1234_5678;
    st0 = stall_seen;
    stall_addr = 32'h0; stall_left = 3;
    send_byte(8'h02); send_byte(8'h00);
    exp_q.push_back('{addr: 32'h0, data: img[0]});
    for (int j = 0; j < 4; j++) send_byte(img[0][8*j +: 8]);
    n = 0;
    @(negedge clk);
    while (cur_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("wr_reload_req", cur_req, 1'b1);
    reload = 1'b1;
    @(posedge clk);
    #1 reload = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin @(negedge clk); n++; end
    chk("wr_reload_done", exp_q.size(), 0);
    @(negedge clk);
    chk("wr_reload_hdr_req", cur_req,     1'b0);
    chk("wr_reload_hdr_rdy", cur_i_ready, 1'b1);
    chk("wr_reload_stalls",  stall_seen - st0, 3);
    img[0] = 32'hCAFE_F00D;
    send_frame(1, 32'h0, 8'h00);
    check_ack(8'h4B, 0, 1'b1);
    pulse_reload();

    // Asynchronous reset during a stalled write drops req at once.
    stall_addr = 32'h0; stall_left = 1000;
    img[0] = 32'h5555_AAAA;
    send_byte(8'h01); send_byte(8'h00);
    exp_q.push_back('{addr: 32'h0, data: img[0]});
    for (int j = 0; j < 4; j++) send_byte(img[0][8*j +: 8]);
    n = 0;
    @(negedge clk);
    while (cur_req !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    chk("arst_req_before", cur_req, 1'b1);
    #2 anrst = 1'b0;
    #1;
    chk("arst_req_after", cur_req,     1'b0);
    chk("arst_i_ready",   cur_i_ready, 1'b1);
    exp_q.delete();
    stall_left = 0;
    @(negedge clk);
    anrst = 1'b1;

    // Small instance: oversize header, then a full image wrapping the address.
    sel = 1'b1;
    send_byte(8'h05); send_byte(8'h00);
    check_ack(8'h45, 0, 1'b0);
    img[0] = 32'h1111_1111; img[1] = 32'h2222_2222;
    img[2] = 32'h3333_3333; img[3] = 32'h4444_4444;
    hs0 = hs_count;
    send_frame(4, 32'hFFFF_FFFC, 8'h00);
    check_ack(8'h4B, 0, 1'b1);
    chk("wrap_handshakes", hs_count - hs0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
